hack_cpu: RTL and testbench

Single-cycle 16-bit Hack-architecture CPU core: decodes one instruction per clock, computes the ALU result combinationally, and updates the A, D and PC registers on the rising edge. It sits between an external instruction ROM (addressed by `pc`) and data RAM (addressed by `addressM`, written via `outM`/`writeM`, read via `inM`).

---
 rtl/hack_cpu_pkg.sv | 20 ++
 rtl/hack_cpu_alu.sv | 29 ++
 rtl/hack_cpu.sv | 54 +++++
 tb/tb_hack_cpu.sv | 120 ++++++++++++
 4 files changed

// File: rtl/hack_cpu_pkg.sv
// hack_cpu_pkg: Hack instruction field positions and shared constants.
package hack_cpu_pkg;
    localparam int W = 16;
    localparam logic [2:0] C_PREFIX = 3'b111;
    localparam int C_HI = 15;
    localparam int C_LO = 13;
    localparam int A_BIT = 12;
    localparam int ZX = 11;
    localparam int NX = 10;
    localparam int ZY = 9;
    localparam int NY = 8;
    localparam int F = 7;
    localparam int NO = 6;
    localparam int D_A = 5;
    localparam int D_D = 4;
    localparam int D_M = 3;
    localparam int J_LT = 2;
    localparam int J_EQ = 1;
    localparam int J_GT = 0;
endpackage

// File: rtl/hack_cpu_alu.sv
// hack_alu: combinational Hack ALU with zero/negative flags.
module hack_alu
    import hack_cpu_pkg::*;
(
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         zx,
    input  logic         nx,
    input  logic         zy,
    input  logic         ny,
    input  logic         f,
    input  logic         no,
    output logic [W-1:0] out,
    output logic         zr,
    output logic         ng
);
    logic [W-1:0] xz, xn, yz, yn, fo;

    always_comb begin
        xz = zx ? '0 : x;
        xn = nx ? ~xz : xz;
        yz = zy ? '0 : y;
        yn = ny ? ~yz : yz;
        fo = f ? xn + yn : xn & yn;
        out = no ? ~fo : fo;
        zr = out == '0;
        ng = out[W-1];
    end
endmodule

// File: rtl/hack_cpu.sv
// hack_cpu: single-cycle Hack CPU core (decode, A/D/PC registers).
// Define HACK_CPU_REGS_RESET_EN to make reset also clear A and D.
module hack_cpu
    import hack_cpu_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] inM,
    input  logic [W-1:0] instruction,
    output logic [W-1:0] outM,
    output logic         writeM,
    output logic [W-1:0] addressM,
    output logic [W-1:0] pc
);
    logic [W-1:0] a, d, y, a_next, d_next;
    logic is_c, zr, ng, jmp;

    hack_alu u_alu (
        .x   (d),
        .y   (y),
        .zx  (instruction[ZX]),
        .nx  (instruction[NX]),
        .zy  (instruction[ZY]),
        .ny  (instruction[NY]),
        .f   (instruction[F]),
        .no  (instruction[NO]),
        .out (outM),
        .zr  (zr),
        .ng  (ng)
    );

    always_comb begin
        is_c = instruction[C_HI:C_LO] == C_PREFIX;
        y = instruction[A_BIT] ? inM : a;
        writeM = is_c & instruction[D_M];
        jmp = is_c & ((ng & instruction[J_LT]) | (zr & instruction[J_EQ]) |
                      (!ng & !zr & instruction[J_GT]));
        a_next = !is_c ? instruction : instruction[D_A] ? outM : a;
        d_next = is_c & instruction[D_D] ? outM : d;
        addressM = a;
    end

    // Jump target uses A as it stood before this edge's A update.
    always_ff @(posedge clk) begin
        pc <= !reset ? '0 : jmp ? a : pc + 16'd1;
`ifdef HACK_CPU_REGS_RESET_EN
        a <= !reset ? '0 : a_next;
        d <= !reset ? '0 : d_next;
`else
        a <= a_next;
        d <= d_next;
`endif
    end
endmodule

// File: tb/tb_hack_cpu.sv
// tb_hack_cpu: directed vectors with a queued scoreboard checked by a negedge monitor.
module tb_hack_cpu;
    logic        clk = 0;
    logic        reset;
    logic [15:0] inM;
    logic [15:0] instruction;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] addressM;
    logic [15:0] pc;

    typedef struct {
        int          tag;
        logic [3:0]  mask;
        logic [15:0] out_m;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] pcv;
    } exp_t;

    exp_t q[$];
    int compared = 0;
    int mismatched = 0;
    int tag_n = 0;

    localparam logic [3:0] M_OUT = 4'b0001, M_WR = 4'b0010, M_AD = 4'b0100, M_PC = 4'b1000;
    localparam logic [3:0] M_ALL = 4'b1111;

`ifdef HACK_CPU_REGS_RESET_EN
    localparam logic [15:0] A_AFTER_RST = 16'h0000;
`else
    localparam logic [15:0] A_AFTER_RST = 16'h0005;
`endif

    hack_cpu dut (
        .clk         (clk),
        .reset       (reset),
        .inM         (inM),
        .instruction (instruction),
        .outM        (outM),
        .writeM      (writeM),
        .addressM    (addressM),
        .pc          (pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input int tag, input string name, input logic [15:0] act, input logic [15:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL step%0d %s actual=%h required=%h", tag, name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            if (e.mask[0]) chk(e.tag, "outM", outM, e.out_m);
            if (e.mask[1]) chk(e.tag, "writeM", {15'd0, writeM}, {15'd0, e.wr});
            if (e.mask[2]) chk(e.tag, "addressM", addressM, e.addr);
            if (e.mask[3]) chk(e.tag, "pc", pc, e.pcv);
        end
    end

    task automatic step(input logic [15:0] ins, input logic rst, input logic [3:0] mask,
                        input logic [15:0] out_m, input logic wr, input logic [15:0] addr,
                        input logic [15:0] pcv);
        exp_t e;
        instruction = ins;
        reset = rst;
        e.tag = tag_n;
        e.mask = mask;
        e.out_m = out_m;
        e.wr = wr;
        e.addr = addr;
        e.pcv = pcv;
        q.push_back(e);
        tag_n++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 0;
        instruction = 16'h0000;
        inM = 16'h0000;
        @(posedge clk);
        #1;
        step(16'h0000, 0, M_AD | M_PC, 0, 0, 16'h0000, 16'h0000);
        step(16'h0000, 1, M_AD | M_PC, 0, 0, 16'h0000, 16'h0000);
        step(16'h0000, 1, M_PC, 0, 0, 0, 16'h0001);
        step(16'h0000, 1, M_PC, 0, 0, 0, 16'h0002);
        step(16'hEA90, 1, M_OUT | M_WR | M_PC, 16'h0000, 0, 0, 16'h0003);
        step(16'h3ACA, 1, M_ALL, 16'hFFFF, 0, 16'h0000, 16'h0004);
        step(16'h0007, 1, M_ALL, 16'h0000, 0, 16'h3ACA, 16'h0005);
        step(16'hEC10, 1, M_ALL, 16'h0007, 0, 16'h0007, 16'h0006);
        step(16'hE308, 1, M_ALL, 16'h0007, 1, 16'h0007, 16'h0007);
        step(16'hEA80, 1, M_ALL, 16'h0000, 0, 16'h0007, 16'h0008);
        step(16'hE301, 1, M_ALL, 16'h0007, 0, 16'h0007, 16'h0009);
        step(16'hE304, 1, M_ALL, 16'h0007, 0, 16'h0007, 16'h0007);
        step(16'h0003, 1, M_WR | M_AD | M_PC, 0, 0, 16'h0007, 16'h0008);
        step(16'hEDE7, 1, M_ALL, 16'h0004, 0, 16'h0003, 16'h0009);
        step(16'h8123, 1, M_ALL, 16'h0003, 0, 16'h0004, 16'h0003);
        step(16'hEEA0, 1, M_ALL, 16'hFFFF, 0, 16'h8123, 16'h0004);
        step(16'hEA87, 1, M_ALL, 16'h0000, 0, 16'hFFFF, 16'h0005);
        step(16'hEA80, 1, M_AD | M_PC, 0, 0, 16'hFFFF, 16'hFFFF);
        step(16'hEA80, 1, M_PC, 0, 0, 0, 16'h0000);
        step(16'h0005, 0, M_AD | M_PC | M_WR, 0, 0, 16'hFFFF, 16'h0001);
        step(16'hEA80, 1, M_ALL, 16'h0000, 0, A_AFTER_RST, 16'h0000);
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        if (q.size() > 0) begin
            mismatched++;
            $display("FAIL drain actual=%0d required=0 pending", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
